// File: rtl/osc_meas_pkg.sv
// Shared types and default widths for the ring-oscillator measurement controller.
// Optional threshold alarm in osc_meas_ctrl is enabled with OSC_MEAS_CTRL_THRESH_EN.
package osc_meas_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int SETTLE_W_DEF = 16;
  localparam int WIN_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous oscillator into wb_clk_i and emits a one-cycle pulse
// per rising edge (3 clk latency from the async edge).
module osc_edge_sync (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic osc_i,
  output logic edge_o
);

  logic r_meta, r_sync, r_prev;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= osc_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign edge_o = r_sync & ~r_prev;

endmodule

// File: rtl/osc_meas_ctrl.sv
// Enables the oscillator, waits a settle period, counts its rising edges over a
// window of clk cycles and publishes the result. Define OSC_MEAS_CTRL_THRESH_EN for the alarm.
module osc_meas_ctrl
  import osc_meas_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int WIN_W    = WIN_W_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [WIN_W-1:0]    window_cycles_i,
  input  logic                osc_i,
`ifdef OSC_MEAS_CTRL_THRESH_EN
  input  logic [CNT_W-1:0]    thr_lo_i,
  input  logic [CNT_W-1:0]    thr_hi_i,
  output logic                alarm_o,
`endif
  output logic                osc_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                ovf_o
);

  localparam int TMR_W = (SETTLE_W > WIN_W) ? SETTLE_W : WIN_W;

  state_e             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [WIN_W-1:0]   r_win_m1;
  logic [CNT_W-1:0]   r_cnt, r_count, w_cnt_nxt;
  logic               r_ovf_stk, r_ovf, r_done, w_ovf_nxt;
  logic               w_edge, w_accept, w_settle_end, w_meas_end, w_cnt_sat;
  logic [SETTLE_W-1:0] w_settle_m1;
  logic [WIN_W-1:0]    w_win_m1;

  osc_edge_sync u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .osc_i    (osc_i),
    .edge_o   (w_edge)
  );

  // Zero lengths behave as one cycle, so the reload value is length-1 floored at 0.
  assign w_settle_m1 = (settle_cycles_i == '0) ? '0 : settle_cycles_i - SETTLE_W'(1);
  assign w_win_m1    = (window_cycles_i == '0) ? '0 : window_cycles_i - WIN_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_settle_end = 1'b0;
    w_meas_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !abort_i) begin
          w_state_nxt = SETTLE;
          w_accept    = 1'b1;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt  = MEASURE;
          w_settle_end = 1'b1;
        end
      end
      MEASURE: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt = IDLE;
          w_meas_end  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge seen in the final MEASURE cycle still lands in the published count.
  assign w_cnt_sat = (r_cnt == '1);
  assign w_cnt_nxt = (w_edge && !w_cnt_sat) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_ovf_nxt = r_ovf_stk | (w_edge & w_cnt_sat);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmr     <= '0;
      r_win_m1  <= '0;
      r_cnt     <= '0;
      r_ovf_stk <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_meas_end;
      if (w_accept) begin
        r_tmr    <= TMR_W'(w_settle_m1);
        r_win_m1 <= w_win_m1;
      end else if (w_settle_end) begin
        r_tmr     <= TMR_W'(r_win_m1);
        r_cnt     <= '0;
        r_ovf_stk <= 1'b0;
      end else if (r_state != IDLE) begin
        r_tmr <= r_tmr - TMR_W'(1);
      end
      if (r_state == MEASURE) begin
        r_cnt     <= w_cnt_nxt;
        r_ovf_stk <= w_ovf_nxt;
      end
      if (w_meas_end) begin
        r_count <= w_cnt_nxt;
        r_ovf   <= w_ovf_nxt;
      end
    end
  end

  assign osc_en_o = (r_state != IDLE);
  assign busy_o   = (r_state != IDLE);
  assign done_o   = r_done;
  assign count_o  = r_count;
  assign ovf_o    = r_ovf;

`ifdef OSC_MEAS_CTRL_THRESH_EN
  logic r_alarm, w_alarm_now;

  // Evaluated against the freshly published result and thresholds in the done cycle.
  assign w_alarm_now = (r_count < thr_lo_i) | (r_count > thr_hi_i) | r_ovf;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)    r_alarm <= 1'b0;
    else if (r_done) r_alarm <= w_alarm_now;
  end

  assign alarm_o = r_done ? w_alarm_now : r_alarm;
`endif

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// Directed self-checking bench for osc_meas_ctrl; a CNT_W=4 copy shares the stimulus
// to exercise saturation.
module tb_osc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] settle = '0;
  logic [15:0] window = '0;
  logic        osc = 1'b0;
  int          osc_half = 2;

  logic        osc_en, busy, done, ovf;
  logic [15:0] count;
  logic        osc_en4, busy4, done4, ovf4;
  logic [3:0]  count4;
`ifdef OSC_MEAS_CTRL_THRESH_EN
  logic [15:0] thr_lo = 16'd20;
  logic [15:0] thr_hi = 16'd30;
  logic [3:0]  thr_lo4 = 4'd0;
  logic [3:0]  thr_hi4 = 4'd15;
  logic        alarm, alarm4;
`endif

  int errors = 0;
  int checks = 0;

  int   en_cnt, done_cnt, done_cyc;
  logic en_h   [0:255];
  logic busy_h [0:255];
  logic [15:0] cnt_at_c;
  logic [15:0] cnt_c1, cnt_c2;

  osc_meas_ctrl #(.CNT_W(16), .SETTLE_W(16), .WIN_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .settle_cycles_i(settle), .window_cycles_i(window), .osc_i(osc),
`ifdef OSC_MEAS_CTRL_THRESH_EN
    .thr_lo_i(thr_lo), .thr_hi_i(thr_hi), .alarm_o(alarm),
`endif
    .osc_en_o(osc_en), .busy_o(busy), .done_o(done), .count_o(count), .ovf_o(ovf)
  );

  osc_meas_ctrl #(.CNT_W(4), .SETTLE_W(16), .WIN_W(16)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .settle_cycles_i(settle), .window_cycles_i(window), .osc_i(osc),
`ifdef OSC_MEAS_CTRL_THRESH_EN
    .thr_lo_i(thr_lo4), .thr_hi_i(thr_hi4), .alarm_o(alarm4),
`endif
    .osc_en_o(osc_en4), .busy_o(busy4), .done_o(done4), .count_o(count4), .ovf_o(ovf4)
  );

  always #5 clk = ~clk;

  // Oscillator toggles every osc_half clk cycles, offset from the clock edge.
  always begin
    repeat (osc_half) @(posedge clk);
    #3 osc = ~osc;
  end

  // Caller is 1 time unit after a posedge. Start is sampled at the next edge (cycle 0);
  // cycles 1..ncyc are then observed. Injection cycle numbers < 0 disable that injection.
  task automatic run(input int s, input int w, input int abort_at, input int restart_at,
                     input int rst_at, input int ncyc, input int cnt_at);
    en_cnt = 0; done_cnt = 0; done_cyc = -1; cnt_at_c = '0;
    settle = 16'(s); window = 16'(w);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      en_h[c] = osc_en; busy_h[c] = busy;
      if (osc_en) en_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == cnt_at) cnt_at_c = count;
      abort = (c == abort_at);
      start = (c == restart_at);
      rst   = (c == rst_at);
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({osc_en, busy, done, ovf} !== 4'b0000 || count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b busy=%b done=%b ovf=%b count=%0d, want all 0",
               osc_en, busy, done, ovf, count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || osc_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b en=%b, want 0 0", busy, osc_en);
    end
  endtask

  task automatic test_basic;
    osc_half = 2;
    run(8, 100, -1, -1, -1, 130, -1);
    checks++;
    if (en_cnt !== 108) begin errors++; $display("FAIL basic_en_cycles: got %0d want 108", en_cnt); end
    checks++;
    if (done_cyc !== 109 || done_cnt !== 1) begin
      errors++; $display("FAIL basic_done: cycle %0d count %0d, want 109 1", done_cyc, done_cnt);
    end
    checks++;
    if (count !== 16'd25 || ovf !== 1'b0) begin
      errors++; $display("FAIL basic_result: count=%0d ovf=%b, want 25 0", count, ovf);
    end
    checks++;
    if (en_h[1] !== 1'b1 || en_h[109] !== 1'b0 || busy_h[108] !== 1'b1) begin
      errors++; $display("FAIL basic_en_edges: en1=%b en109=%b busy108=%b, want 1 0 1",
                         en_h[1], en_h[109], busy_h[108]);
    end
`ifdef OSC_MEAS_CTRL_THRESH_EN
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL basic_alarm: got %b want 0", alarm); end
`endif
  endtask

  task automatic test_abort;
    osc_half = 2;
    run(8, 100, 50, -1, -1, 130, -1);
    checks++;
    if (en_h[50] !== 1'b1 || en_h[51] !== 1'b0 || busy_h[51] !== 1'b0) begin
      errors++; $display("FAIL abort_stop: en50=%b en51=%b busy51=%b, want 1 0 0",
                         en_h[50], en_h[51], busy_h[51]);
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt); end
    checks++;
    if (count !== 16'd25 || ovf !== 1'b0) begin
      errors++; $display("FAIL abort_keeps_count: count=%0d ovf=%b, want 25 0", count, ovf);
    end
  endtask

  task automatic test_start_abort_same;
    start = 1'b1; abort = 1'b1; settle = 16'd8; window = 16'd100;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || osc_en !== 1'b0) begin
      errors++; $display("FAIL start_abort_same: busy=%b en=%b, want 0 0", busy, osc_en);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    osc_half = 2;
    run(8, 100, -1, 20, -1, 140, -1);
    checks++;
    if (done_cyc !== 109 || done_cnt !== 1) begin
      errors++; $display("FAIL busy_start_ignored: done cycle %0d count %0d, want 109 1", done_cyc, done_cnt);
    end
    checks++;
    if (en_h[110] !== 1'b0) begin errors++; $display("FAIL busy_start_no_rerun: en110=%b want 0", en_h[110]); end
  endtask

  task automatic test_zero_cfg;
    run(0, 0, -1, -1, -1, 10, -1);
    checks++;
    if (done_cyc !== 3 || done_cnt !== 1) begin
      errors++; $display("FAIL zero_done: cycle %0d count %0d, want 3 1", done_cyc, done_cnt);
    end
    checks++;
    if (en_cnt !== 2) begin errors++; $display("FAIL zero_en_cycles: got %0d want 2", en_cnt); end
  endtask

  task automatic test_saturation;
    osc_half = 2;
    run(8, 100, -1, -1, -1, 115, -1);
    checks++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1) begin
      errors++; $display("FAIL sat_result: count=%0d ovf=%b, want 15 1", count4, ovf4);
    end
    checks++;
    if (count !== 16'd25 || ovf !== 1'b0) begin
      errors++; $display("FAIL sat_wide_result: count=%0d ovf=%b, want 25 0", count, ovf);
    end
    run(8, 20, -1, -1, -1, 35, -1);
    checks++;
    if (count4 !== 4'd5 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL sat_recover: count=%0d ovf=%b, want 5 0", count4, ovf4);
    end
  endtask

  task automatic test_reset_mid;
    osc_half = 2;
    run(8, 100, -1, -1, 60, 130, 61);
    checks++;
    if (en_h[60] !== 1'b1 || en_h[61] !== 1'b0 || busy_h[61] !== 1'b0 || cnt_at_c !== 16'd0) begin
      errors++; $display("FAIL reset_mid_outputs: en60=%b en61=%b busy61=%b count61=%0d, want 1 0 0 0",
                         en_h[60], en_h[61], busy_h[61], cnt_at_c);
    end
    checks++;
    if (done_cnt !== 0 || count !== 16'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_done: dones=%0d count=%0d ovf=%b, want 0 0 0", done_cnt, count, ovf);
    end
  endtask

`ifdef OSC_MEAS_CTRL_THRESH_EN
  task automatic test_thresh;
    osc_half = 4;
    run(8, 100, -1, -1, -1, 115, -1);
    checks++;
    if (count !== 16'd12 && count !== 16'd13) begin
      errors++; $display("FAIL thr_slow_count: got %0d want 12 or 13", count);
    end
    checks++;
    if (alarm !== 1'b1) begin errors++; $display("FAIL thr_alarm_low: got %b want 1", alarm); end
    osc_half = 2;
    run(8, 100, 40, -1, -1, 60, -1);
    checks++;
    if (alarm !== 1'b1) begin errors++; $display("FAIL thr_alarm_held: got %b want 1", alarm); end
    run(8, 100, -1, -1, -1, 115, -1);
    checks++;
    if (alarm !== 1'b0 || count !== 16'd25) begin
      errors++; $display("FAIL thr_alarm_clear: alarm=%b count=%0d, want 0 25", alarm, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_start_abort_same();
    test_back_to_back();
    test_zero_cfg();
    test_saturation();
    test_reset_mid();
`ifdef OSC_MEAS_CTRL_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
